// File: rtl/frame_writer_pkg.sv
// Shared pixel types and frame-writer FSM encoding.
// RGB565 packing helper used by frame_writer (FRAME_WRITER_RGB565_EN).
package frame_writer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    DONE
  } frame_state_t;

  function automatic rgb565_t to_rgb565(
    input pixel_t p
  );
    rgb565_t q;
    q.r = p.r[7:3];
    q.g = p.g[7:2];
    q.b = p.b[7:3];
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output.
// dout_o always shows the oldest entry while !empty_o.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = dout_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head register tracks the next oldest entry, bypassing din on empty.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push && (wr_q == rd_d)) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Raster pixel stream to linear framebuffer writer.
// FRAME_WRITER_RGB565_EN packs two RGB565 pixels per word.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                      pixel_clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [31:0]               pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic [$clog2(WIDTH)-1:0]  cur_x,
  output logic [$clog2(HEIGHT)-1:0] cur_y,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CW:0]   RDY_MAX = (CW+1)'(FIFO_DEPTH - 2);

  frame_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              rdy_q, rdy_d;
  logic              clr;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [CW:0]       occ_next;
  logic              xfer;
  logic              last;

  assign xfer = pixel_valid && rdy_q && !full;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign pop  = !empty && mem_ready;

`ifdef FRAME_WRITER_RGB565_EN
  if (((WIDTH * HEIGHT) % 2) != 0) begin : g_odd_frame
    $error("frame_writer: WIDTH*HEIGHT must be even for RGB565");
  end

  logic    half_q, half_d;
  rgb565_t lo_q, lo_d;

  assign push = xfer && half_q;
  assign din  = {to_rgb565(pixel_t'(pixel_data)), lo_q};

  // Even pixel parks in lo_q until its odd partner arrives.
  always_comb begin
    half_d = half_q;
    lo_d   = lo_q;
    if (clr) begin
      half_d = 1'b0;
    end else if (xfer) begin
      half_d = !half_q;
      if (!half_q) lo_d = to_rgb565(pixel_t'(pixel_data));
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      lo_q   <= '0;
    end else begin
      half_q <= half_d;
      lo_q   <= lo_d;
    end
  end
`else
  assign push = xfer;
  assign din  = pixel_data;
`endif

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (pixel_clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .dout_o  (dout)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    x_d     = x_q;
    y_d     = y_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          base_d  = base_addr;
          x_d     = '0;
          y_d     = '0;
          clr     = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is a registered function of next occupancy: no mem_ready path.
  always_comb begin
    occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    rdy_d    = (state_d == ACTIVE) && (occ_next <= RDY_MAX);
    widx_d   = widx_q;
    if (clr) begin
      widx_d = '0;
    end else if (pop) begin
      widx_d = widx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      widx_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      widx_q  <= widx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rdy_q   <= rdy_d;
    end
  end

  assign pixel_ready = rdy_q;
  assign cur_x       = x_q;
  assign cur_y       = y_q;
  assign mem_we      = !empty;
  assign mem_wdata   = dout;
  assign mem_addr    = base_q + (widx_q << 2);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer on a 4x2 frame.
// Expected words are built at acceptance and checked on memory writes.
module tb_frame_writer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 8;
`ifdef FRAME_WRITER_RGB565_EN
  localparam int STALL_ACC = W * H;
`else
  localparam int STALL_ACC = D - 1;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [1:0]  cur_x;
  logic [0:0]  cur_y;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        frame_done;

  frame_writer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (D),
    .ADDR_W     (32)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_base = '0;
  int          exp_idx = 0;
  int          exp_x = 0;
  int          exp_y = 0;
  int          acc_cnt = 0;
  int          seq = 0;
  bit          half = 0;
  logic [15:0] lo = '0;
  bit          stall_q = 0;
  logic [31:0] held_a = '0;
  logic [31:0] held_d = '0;
  bit          v_rand = 0;
  bit          m_rand = 0;
  bit          v_hold = 0;
  bit          m_hold = 0;
  bit          inj_done = 0;
  bit          chk_first = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int s);
    logic [7:0] b;
    b = 8'(s);
    if (s == 0) return 32'hFF0000FF;
    if (s == 1) return 32'h00FF00FF;
    return {8'hC0, b, ~b, 8'h5A};
  endfunction

  function automatic logic [15:0] c565(input logic [31:0] d);
    return {d[31:27], d[23:18], d[15:11]};
  endfunction

  always @(negedge pixel_clk) begin
    if (rst_n) begin
      if (pixel_valid && pixel_ready) begin
        chk("cur_x", 64'(cur_x), 64'(exp_x));
        chk("cur_y", 64'(cur_y), 64'(exp_y));
`ifdef FRAME_WRITER_RGB565_EN
        if (!half) begin
          lo   = c565(pixel_data);
          half = 1;
        end else begin
          sb.push_back({exp_base + 32'(exp_idx * 4),
                        c565(pixel_data), lo});
          exp_idx++;
          half = 0;
        end
`else
        sb.push_back({exp_base + 32'(exp_idx * 4), pixel_data});
        exp_idx++;
`endif
        if (exp_x == W - 1) begin
          exp_x = 0;
          exp_y = (exp_y == H - 1) ? 0 : exp_y + 1;
        end else begin
          exp_x++;
        end
        acc_cnt++;
        seq++;
      end
      if (mem_we) begin
        if (stall_q) begin
          chk("hold_addr", 64'(mem_addr), 64'(held_a));
          chk("hold_data", 64'(mem_wdata), 64'(held_d));
        end
        if (mem_ready) begin
          if (sb.size() == 0) begin
            chk("extra_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF);
          end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("mem_addr", 64'(mem_addr), 64'(e[63:32]));
            chk("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
          end
          if (chk_first) begin
            chk("rgb565_word", 64'(mem_wdata), 64'h07E0F800);
            chk_first = 0;
          end
        end
        stall_q = !mem_ready;
        held_a  = mem_addr;
        held_d  = mem_wdata;
      end else begin
        stall_q = 0;
      end
      if (frame_done) begin
        n_done++;
        chk("done_drained", 64'(mem_we), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    frame_start = 1'b0;
    pixel_valid = v_rand ? 1'($urandom_range(0, 1)) : v_hold;
    pixel_data  = v_rand ? $urandom : pix(seq);
    mem_ready   = m_rand ? ($urandom_range(0, 3) != 0) : m_hold;
    if (inj_done && frame_done) begin
      frame_start = 1'b1;
      base_addr   = 32'h0000_A000;
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    base_addr   = base;
    frame_start = 1'b1;
    exp_base    = base;
    exp_idx     = 0;
    exp_x       = 0;
    exp_y       = 0;
    acc_cnt     = 0;
    seq         = 0;
    half        = 0;
    pixel_data  = pix(0);
    tick();
  endtask

  task automatic wait_done(input int lim, input int inj_at);
    int d0;
    int n;
    d0 = n_done;
    n  = 0;
    while (n_done == d0 && n < lim) begin
      tick();
      if (n == inj_at) begin
        frame_start = 1'b1;
        base_addr   = 32'h0000_9000;
      end
      n++;
    end
    chk("done_seen", 64'(n_done != d0), 64'd1);
  endtask

  task automatic end_checks(input int d0);
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("x_end", 64'(cur_x), 64'd0);
    chk("y_end", 64'(cur_y), 64'd0);
    chk("done_once", 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    int d0;
    int n;
    repeat (2) tick();
    @(negedge pixel_clk);
    chk("rst_ready", 64'(pixel_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_xy", 64'({cur_x, cur_y}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Streaming frame, memory always ready.
    v_hold = 1;
    m_hold = 1;
`ifdef FRAME_WRITER_RGB565_EN
    chk_first = 1;
`endif
    d0 = n_done;
    start_frame(32'h0000_1000);
    wait_done(100, -1);
    end_checks(d0);

    // Memory stalled for 20 cycles.
    m_hold = 0;
    d0 = n_done;
    start_frame(32'h0000_1000);
    repeat (20) tick();
    chk("stall_acc", 64'(acc_cnt), 64'(STALL_ACC));
    chk("stall_rdy", 64'(pixel_ready), 64'd0);
    chk("stall_we", 64'(mem_we), 64'd1);
    m_hold = 1;
    wait_done(100, -1);
    end_checks(d0);

    // frame_start in ACTIVE and in DONE is ignored.
    m_rand = 1;
    inj_done = 1;
    d0 = n_done;
    start_frame(32'h0000_2000);
    wait_done(200, 2);
    end_checks(d0);
    inj_done = 0;
    chk("no_relatch", 64'(mem_addr), 64'(exp_base + 32'(exp_idx * 4)));

    // Reset with pixels buffered mid-frame.
    m_rand = 0;
    m_hold = 0;
    start_frame(32'h0000_5000);
    n = 0;
    while (acc_cnt < 3 && n < 20) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_we", 64'(mem_we), 64'd0);
    chk("mrst_ready", 64'(pixel_ready), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_addr", 64'(mem_addr), 64'd0);
    chk("mrst_wdata", 64'(mem_wdata), 64'd0);
    chk("mrst_xy", 64'({cur_x, cur_y}), 64'd0);
    sb.delete();
    half    = 0;
    stall_q = 0;
    #2;
    rst_n  = 1'b1;
    m_hold = 1;
    repeat (2) tick();
    d0 = n_done;
    start_frame(32'h0000_3000);
    wait_done(100, -1);
    end_checks(d0);

    // Random valid and memory backpressure.
    v_rand = 1;
    m_rand = 1;
    for (int f = 0; f < 30; f++) begin
      d0 = n_done;
      start_frame(32'h0001_0000 + 32'(f * 256));
      wait_done(300, -1);
      end_checks(d0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Consumer end of the 32-bit RGBA `pixel_data` stream produced by the scene/shading path.
- Accepts pixels in raster order through a valid/ready handshake and buffers them in a small FIFO.
- Writes each buffered pixel to a linear framebuffer over a simple write-only memory port.
- Tracks the x/y position within the frame and pulses `frame_done` once the last pixel is committed to memory.

Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, minimum 2
- ADDR_W, 32, memory address width

Ports:
- pixel_clk  input  1  sole clock
- rst_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle pulse; begins a frame, sampled only in IDLE
- base_addr  input  ADDR_W  framebuffer byte base address, latched on an accepted frame_start
- pixel_data  input  32  RGBA pixel, 8 bits per channel, format RRGGBBAA
- pixel_valid  input  1  pixel_data is valid
- pixel_ready  output  1  writer accepts pixel_data this cycle
- cur_x  output  clog2(WIDTH)  x of the next pixel to be accepted
- cur_y  output  clog2(HEIGHT)  y of the next pixel to be accepted
- mem_addr  output  ADDR_W  write byte address
- mem_wdata  output  32  write data
- mem_we  output  1  write request
- mem_ready  input  1  memory accepts the write this cycle
- busy  output  1  high whenever the FSM is not in IDLE
- frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- Reset asserted mid-frame: buffered pixels are discarded; no memory write completes after reset assertion.
- FSM states: IDLE, ACTIVE, FLUSH, DONE.
- IDLE:
  - pixel_ready=0.
  - On frame_start: latch base_addr, clear all counters, go to ACTIVE.
- ACTIVE:
  - pixel_ready is registered: 1 when FIFO occupancy is at most FIFO_DEPTH-2 after the current cycle's push/pop. This gives no combinational path from mem_ready to pixel_ready.
  - A transfer occurs when pixel_valid && pixel_ready.
  - On each transfer, cur_x increments. At WIDTH-1 it wraps to 0 and cur_y increments.
  - The transfer at (WIDTH-1, HEIGHT-1) moves the FSM to FLUSH, with pixel_ready=0 from the next cycle.
  - pixel_data is ignored when pixel_valid=0.
- FLUSH:
  - Stays until the FIFO is empty and no write is pending, then goes to DONE.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
  - busy falls in the same cycle the FSM enters IDLE.
- frame_start is ignored outside IDLE, including in the DONE cycle.
- Memory side, independent of the FSM:
  - mem_we=1 whenever the FIFO head is valid.
  - mem_addr = base_addr + 4 × write_index, where write_index counts completed writes.
  - mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
  - A write completes on mem_we && mem_ready; the FIFO pops, write_index increments, and the next entry (if any) presents on the following cycle.
- Latency: a pixel accepted in cycle N is visible on mem_wdata no earlier than cycle N+1 (FIFO read is registered).
- FIFO ordering: simultaneous push and pop are legal, occupancy is unchanged, and order is preserved.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.

Optional Feature:
- Macro FRAME_WRITER_RGB565_EN.
- When defined:
  - Each pixel is converted to RGB565 (R[7:3], G[7:2], B[7:3]); alpha is dropped.
  - Two consecutive pixels are packed per memory word: the even pixel in bits [15:0], the odd pixel in [31:16].
  - Only full words are pushed into the FIFO.
  - mem_addr = base_addr + 4 × word_index.
  - WIDTH×HEIGHT must be even; this is checked by an elaboration assertion.
- When undefined: one 32-bit RGBA pixel per word, unchanged.

Decomposition:
- graphics package gains:
  - pixel_t: packed struct with fields r, g, b, a, 8 bits each.
  - rgb565_t: 16-bit packed struct.
  - to_rgb565 function.
  - frame_state_t enum (IDLE, ACTIVE, FLUSH, DONE).
- One sub-module: sync_fifo (parameters DEPTH and WIDTH; ports push, pop, full, empty, count, registered dout). It is reused later by other stream stages.

Test Plan:
- WIDTH=4, HEIGHT=2, base_addr=0x1000, pixel_valid held 1, mem_ready tied 1:
  - 8 writes to 0x1000..0x101C, data in order.
  - frame_done pulses once, 1 cycle after FLUSH drains.
  - cur_x/cur_y step through (0,0)..(3,1) and return to 0.
- Same frame with mem_ready low for 20 cycles:
  - pixel_ready falls after FIFO_DEPTH-1 pixels.
  - mem_addr and mem_wdata are stable throughout the stall.
  - No pixel is lost or duplicated.
- Random pixel_valid and random mem_ready, 1000 cycles, 16×16 frame:
  - Scoreboard matches all 256 words.
  - frame_done is seen exactly once.
- frame_start pulsed during ACTIVE and during DONE:
  - Ignored; base_addr is not re-latched; the counters are unaffected.
- rst_n asserted with 3 entries in the FIFO and the FSM in ACTIVE:
  - mem_we falls immediately; all outputs read 0.
  - A following frame_start runs a clean frame.
- FRAME_WRITER_RGB565_EN defined; pixels 0xFF0000FF then 0x00FF00FF:
  - Single write 0x07E0F800 to base_addr.
